fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
- Read-domain controller of the asynchronous FIFO.
- Sequences reads from the dual-port memory and owns the binary/Gray read pointer.
- Derives the empty flag from the write pointer after the 2-flop Gray synchronizer has brought it into this domain.
- Presents a first-word-fall-through (FWFT) valid/ready read interface to the consumer, and exports the Gray read pointer for synchronization back into the write domain.

Parameters:
- ADDR_WIDTH, 4: memory address bits. Depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8: word width.

Ports:
- clk_trg  in  1: read-domain clock; all logic is on its rising edge.
- rst_trg  in  1: asynchronous, active-high reset.
- wptr_gray_sync  in  ADDR_WIDTH+1: write pointer (Gray), already synchronized into this domain.
- mem_rd_en  out  1: memory read strobe. Synchronous RAM; data is valid the cycle after the strobe.
- mem_rd_addr  out  ADDR_WIDTH: memory read address, equal to rptr_bin[ADDR_WIDTH-1:0].
- mem_rd_data  in  DATA_WIDTH: memory read data, registered inside the RAM.
- rd_valid  out  1: rd_data holds the head word.
- rd_ready  in  1: consumer accepts; transfer occurs on rd_valid && rd_ready.
- rd_data  out  DATA_WIDTH: head word, driven combinationally from mem_rd_data.
- rptr_gray  out  ADDR_WIDTH+1: registered Gray read pointer, sent to the write-domain synchronizer.
- empty  out  1: registered; no unread word remains in memory.

Behaviour:
- Reset (async assert, sync release):
  - rptr_bin=0, rptr_gray=0
  - empty=1, rd_valid=0, mem_rd_en=0
  - FSM in S_EMPTY
- Pointers:
  - rptr_bin increments by 1 per fetch, modulo 2^(ADDR_WIDTH+1).
  - rptr_gray is registered as (next_bin>>1)^next_bin, so only one bit changes per edge.
  - Wrap from all-ones to 0 is legal and gives a single-bit Gray change.
- Empty:
  - empty_next = (rptr_gray_next == wptr_gray_sync), registered every cycle.
  - The MSB distinguishes wrap; equality on all ADDR_WIDTH+1 bits means empty.
- Fetch rule: mem_rd_en = !empty && (!rd_valid || rd_ready) && state != S_EMPTY-with-empty. Equivalently, fetch whenever memory holds data and the output slot is free or being freed this cycle.
- FSM:
  - S_EMPTY: rd_valid=0. On fetch, go to S_VALID at the next edge, with rd_valid=1 and mem_rd_data holding the word.
  - S_VALID: rd_valid=1.
    - Transfer with fetch: stay in S_VALID (back-to-back, 1 word/cycle).
    - Transfer without fetch (empty): go to S_EMPTY.
    - No transfer: hold; mem_rd_en=0, so data is held stable.
- Latency: a write pointer change seen at wptr_gray_sync gives empty=0 after 1 edge, fetch in that cycle, and rd_valid=1 after the next edge. Total 2 clk_trg cycles from sync output to rd_valid.
- rd_ready while rd_valid=0 is ignored.
- rd_valid never drops without a transfer; rd_data is stable while rd_valid && !rd_ready.
- wptr_gray_sync is treated as monotonic. A change of more than one code step between samples is tolerated; empty uses equality only.
- Overflow and underflow are impossible by construction: no fetch happens while empty=1.
- Reset mid-transfer: all state is cleared immediately and the in-flight word is discarded. The write side must be reset together with this block.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- With the macro defined:
  - Adds output rd_level [ADDR_WIDTH:0], registered, reset 0.
  - rd_level = bin(wptr_gray_sync) − rptr_bin_next, modulo 2^(ADDR_WIDTH+1).
  - The Gray-to-binary conversion is an XOR-prefix from the MSB.
  - rd_level counts words still in memory and excludes the word held on rd_data.
- Without the macro: the port and the conversion logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg holds:
  - PTR_WIDTH = ADDR_WIDTH+1
  - functions bin2gray and gray2bin
  - FSM state encoding S_EMPTY=1'b0, S_VALID=1'b1
- One sub-module, gray_ptr:
  - Parameterized binary+Gray pointer register with increment enable.
  - Outputs bin, gray and gray_next.
  - Reusable by the write-side controller.

Test Plan (ADDR_WIDTH=4):
- Reset: hold rst_trg=1 for 3 cycles with wptr_gray_sync=0 → rd_valid=0, empty=1, rptr_gray=0, mem_rd_en=0 throughout; release → no change.
- Single word: wptr_gray_sync 0→1 (bin 1) → empty=0 after 1 edge; mem_rd_en=1, mem_rd_addr=0; rd_valid=1 the next cycle. Accept with rd_ready=1 → rptr_gray=1, empty=1, rd_valid=0.
- Burst: wptr set to bin 5 (gray 7), rd_ready=1 constant → 5 consecutive mem_rd_en pulses, addrs 0..4, rd_valid high 5 contiguous cycles. Final rptr_gray=7, empty=1.
- Backpressure: 3 words available, rd_ready=0 for 4 cycles → one fetch only, rd_data stable, rd_valid=1, no further mem_rd_en. Release → remaining 2 words at 1/cycle.
- Wrap: stream 40 words (wptr advanced stepwise) → mem_rd_addr wraps 15→0 twice, rptr_bin wraps 31→0. Each rptr_gray change flips exactly one bit; data order is preserved.
- FIFO_RD_LEVEL_EN: wptr bin 9, rptr 0 → rd_level=9, then 8 after the first fetch. With wptr bin 2 and rptr bin 30 → rd_level=4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the asynchronous FIFO controllers.
// Helpers operate on a 32-bit container; callers cast to their pointer width.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int PTR_WIDTH      = DEF_ADDR_WIDTH + 1;
    localparam int FN_WIDTH       = 32;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_VALID = 1'b1
    } rd_state_e;

    function automatic logic [FN_WIDTH-1:0] bin2gray(
        input logic [FN_WIDTH-1:0] b
    );
        return (b >> 1) ^ b;
    endfunction

    // Zero-extended codes stay correct: the prefix XOR of leading zeros is zero.
    function automatic logic [FN_WIDTH-1:0] gray2bin(
        input logic [FN_WIDTH-1:0] g
    );
        logic [FN_WIDTH-1:0] b;
        b[FN_WIDTH-1] = g[FN_WIDTH-1];
        for (int i = FN_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr.sv
// Binary + Gray pointer register with increment enable.
// Shared by the read-side and write-side FIFO controllers.
module gray_ptr
    import fifo_pkg::*;
#(
    parameter int WIDTH = PTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] gray_next
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    always_comb begin
        bin_d  = bin_q + WIDTH'(inc);
        gray_d = WIDTH'(bin2gray(FN_WIDTH'(bin_d)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin       = bin_q;
    assign gray      = gray_q;
    assign gray_next = gray_d;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO with an FWFT consumer interface.
// Define FIFO_RD_LEVEL_EN to add the registered rd_level output.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_trg,
    input  logic                  rst_trg,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   rptr_gray,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDR_WIDTH:0]   rd_level,
`endif
    output logic                  empty
);

    localparam int PW = ADDR_WIDTH + 1;

    rd_state_e     state_q;
    rd_state_e     state_d;
    logic          empty_q;
    logic          empty_d;
    logic          fetch;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_gray_next;

    gray_ptr #(
        .WIDTH(PW)
    ) u_rptr (
        .clk      (clk_trg),
        .rst      (rst_trg),
        .inc      (fetch),
        .bin      (rptr_bin),
        .gray     (rptr_gray),
        .gray_next(rptr_gray_next)
    );

    // Fetch when memory has data and the output slot is free or being freed.
    always_comb begin
        fetch   = !empty_q && (state_q == S_EMPTY || rd_ready);
        empty_d = (rptr_gray_next == wptr_gray_sync);
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: if (fetch) state_d = S_VALID;
            S_VALID: if (rd_ready && !fetch) state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_trg or posedge rst_trg) begin
        if (rst_trg) begin
            state_q <= S_EMPTY;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            empty_q <= empty_d;
        end
    end

    assign mem_rd_en   = fetch;
    assign mem_rd_addr = rptr_bin[ADDR_WIDTH-1:0];
    assign rd_valid    = (state_q == S_VALID);
    assign rd_data     = mem_rd_data;
    assign empty       = empty_q;

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_d;
    logic [PW-1:0] wptr_bin;

    // Words still in memory, not counting the one presented on rd_data.
    always_comb begin
        wptr_bin = PW'(gray2bin(FN_WIDTH'(wptr_gray_sync)));
        level_d  = wptr_bin - (rptr_bin + PW'(fetch));
    end

    always_ff @(posedge clk_trg or posedge rst_trg) begin
        if (rst_trg) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rd_level = level_q;
`else
    logic unused_rptr_msb;
    assign unused_rptr_msb = rptr_bin[ADDR_WIDTH];
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed phases plus random traffic
// checked against a word-count model of the FIFO read side.
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk_trg = 1'b0;
    logic          rst_trg;
    logic [AW:0]   wptr_gray_sync;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW:0]   rptr_gray;
    logic          empty;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW:0]   rd_level;
`endif

    fifo_rd_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_trg       (clk_trg),
        .rst_trg       (rst_trg),
        .wptr_gray_sync(wptr_gray_sync),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rptr_gray     (rptr_gray),
`ifdef FIFO_RD_LEVEL_EN
        .rd_level      (rd_level),
`endif
        .empty         (empty)
    );

    always #5 clk_trg = ~clk_trg;

    // Synchronous RAM: data appears the cycle after the strobe.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk_trg) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    // Model: absolute counts of words published, fetched and consumed.
    logic [DW-1:0] words[$];
    int wbin;
    int fetched;
    int consumed;
    bit m_valid;
    bit m_empty;
    int m_level;

    function automatic logic [AW:0] to_gray(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        words.delete();
        wbin     = 0;
        fetched  = 0;
        consumed = 0;
        m_valid  = 0;
        m_empty  = 1;
        m_level  = 0;
    endtask

    task automatic publish(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (wbin - fetched < DEPTH) begin
                d = DW'($urandom);
                mem[wbin % DEPTH] = d;
                words.push_back(d);
                wbin++;
            end
        end
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic step(input logic rdy);
        bit fetch;
        rd_ready       = rdy;
        wptr_gray_sync = to_gray(wbin);
        #1;
        fetch = !m_empty && (!m_valid || rdy);
        chk("rd_valid", rd_valid, m_valid);
        chk("empty", empty, m_empty);
        chk("rptr_gray", rptr_gray, to_gray(fetched));
        chk("mem_rd_en", mem_rd_en, fetch);
        if (fetch) chk("mem_rd_addr", mem_rd_addr, fetched % DEPTH);
        if (m_valid) chk("rd_data", rd_data, words[consumed]);
`ifdef FIFO_RD_LEVEL_EN
        chk("rd_level", rd_level, m_level);
`endif
        if (m_valid && rdy) consumed++;
        if (fetch) fetched++;
        m_valid = fetch || (m_valid && !rdy);
        m_empty = (fetched == wbin);
        m_level = (wbin - fetched) % (2 * DEPTH);
        @(posedge clk_trg);
        @(negedge clk_trg);
    endtask

    initial begin
        int pushed;
        rst_trg        = 1'b1;
        rd_ready       = 1'b0;
        wptr_gray_sync = '0;
        model_reset();

        repeat (3) begin
            @(negedge clk_trg);
            #1;
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_empty", empty, 1);
            chk("rst_rptr_gray", rptr_gray, 0);
            chk("rst_mem_rd_en", mem_rd_en, 0);
        end
        rst_trg = 1'b0;
        @(negedge clk_trg);
        repeat (2) step(1'b0);

        // Single word, accepted once presented.
        publish(1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);

        // Burst of four more words (write pointer at 5).
        publish(4);
        repeat (8) step(1'b1);

        // Backpressure then release.
        publish(3);
        repeat (6) step(1'b0);
        repeat (5) step(1'b1);

        // Stream 40 words so both the address and the pointer wrap.
        pushed = 0;
        repeat (60) begin
            if (pushed < 40 && wbin - fetched < DEPTH) begin
                publish(1);
                pushed++;
            end
            step(1'b1);
        end

        // Random traffic, including multi-step pointer jumps.
        repeat (400) begin
            publish($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0);
        end
        repeat (25) step(1'b1);

        // Asynchronous reset while a word is presented.
        publish(5);
        repeat (3) step(1'b0);
        #2;
        rst_trg        = 1'b1;
        wptr_gray_sync = '0;
        #1;
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_empty", empty, 1);
        chk("arst_rptr_gray", rptr_gray, 0);
        chk("arst_mem_rd_en", mem_rd_en, 0);
        model_reset();
        @(negedge clk_trg);
        @(negedge clk_trg);
        rst_trg = 1'b0;
        repeat (2) step(1'b0);
        publish(2);
        repeat (6) step(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
